// File: rtl/pwf_pkg.sv
// Shared types and defaults for the pulse-width meter.
// - meter_state_t : measurement FSM states
// - meas_t        : one queued measurement {sat, width} at the default width
package pwf_pkg;

    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int PCNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } meter_state_t;

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] width;
    } meas_t;

endpackage

// File: rtl/pwf_pulse_meter_if.sv
// Measurement result channel from the pulse meter to the host.
// Ports (signals):
//   meas_width  head entry pulse length in cycles
//   meas_sat    head entry length saturated
//   meas_valid  an entry is available
//   meas_ready  host accepts the head entry
// Handshake: an entry transfers on every clock edge where meas_valid and
// meas_ready are both 1. While meas_valid=1 and meas_ready=0 the payload is
// held stable; meas_valid never drops without a transfer; meas_ready while
// meas_valid=0 has no effect.
interface pwf_pulse_meter_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] meas_width;
    logic             meas_sat;
    logic             meas_valid;
    logic             meas_ready;

    modport master (
        output meas_width,
        output meas_sat,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        input  meas_width,
        input  meas_sat,
        input  meas_valid,
        output meas_ready
    );
endinterface

// File: rtl/pwf_meas_fifo.sv
// Small synchronous FIFO for measurement entries.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   dout        head entry (meaningful when !empty)
//   full, empty occupancy flags
module pwf_meas_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = pwf_pkg::meas_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write lands in.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pwf_pulse_meter.sv
// Measures the high time of each filtered pulse on c_in in clk4m cycles and
// queues the results for the host.
// Ports:
//   clk4m, rst_n  clock, asynchronous active-low reset
//   c_in          filtered pulse, already synchronous to clk4m
//   clr           synchronous clear of pulse_cnt and overflow
//   meas          result channel (master side)
//   pulse_cnt     completed pulses, dropped ones included; wraps
//   overflow      sticky: a result was dropped because the FIFO was full
//   state_dbg     current FSM state
module pwf_pulse_meter #(
    parameter int CNT_W  = pwf_pkg::CNT_W,
    parameter int DEPTH  = pwf_pkg::DEPTH,
    parameter int PCNT_W = pwf_pkg::PCNT_W
) (
    input  logic                 clk4m,
    input  logic                 rst_n,
    input  logic                 c_in,
    input  logic                 clr,
    pwf_pulse_meter_if.master    meas,
    output logic [PCNT_W-1:0]    pulse_cnt,
    output logic                 overflow,
    output pwf_pkg::meter_state_t state_dbg
);
    import pwf_pkg::*;

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] width;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t     state, state_nx;
    logic             c_d;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sat_r, sat_nx;
    logic             done;
    logic             push_r;
    entry_t           push_data;
    entry_t           head;
    logic             full, empty, pop, drop;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sat_nx   = sat_r;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (c_in && !c_d) begin
                    cnt_nx   = CNT_W'(1);
                    state_nx = MEAS;
                end
            end
            MEAS: begin
                if (c_in) begin
                    // Saturated flag marks that at least one cycle was lost.
                    if (cnt == CNT_MAX) sat_nx = 1'b1;
                    else                cnt_nx = cnt + 1'b1;
                end else begin
                    done     = 1'b1;
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // c_d resets high so a pulse already in progress at reset release is
    // not mistaken for a rising edge. The finished measurement is staged one
    // cycle (push_r) before entering the FIFO.
    always_ff @(posedge clk4m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c_d       <= 1'b1;
            cnt       <= '0;
            sat_r     <= 1'b0;
            push_r    <= 1'b0;
            push_data <= '0;
            pulse_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state           <= state_nx;
            c_d             <= c_in;
            cnt             <= cnt_nx;
            sat_r           <= sat_nx;
            push_r          <= done;
            push_data.sat   <= sat_r;
            push_data.width <= cnt;
            if (clr)       pulse_cnt <= '0;
            else if (done) pulse_cnt <= pulse_cnt + 1'b1;
            if (clr)       overflow  <= 1'b0;
            else if (drop) overflow  <= 1'b1;
        end
    end

    assign pop  = !empty && meas.meas_ready;
    assign drop = push_r && full && !pop;

    pwf_meas_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk4m),
        .rst_n (rst_n),
        .push  (push_r),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Payload forced to zero when empty so stale RAM contents never show.
    assign meas.meas_valid = !empty;
    assign meas.meas_width = empty ? '0 : head.width;
    assign meas.meas_sat   = empty ? 1'b0 : head.sat;
    assign state_dbg       = state;
endmodule

// File: tb/tb_pwf_pulse_meter.sv
`timescale 1ns/1ps
module tb_pwf_pulse_meter;
    localparam int CW   = 4;
    localparam int DEP  = 4;
    localparam int PW   = 16;
    localparam int MAXW = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk4m = 1'b0;
    logic rst_n = 1'b0;
    logic c_in  = 1'b0;
    logic clr   = 1'b0;
    logic [PW-1:0] pulse_cnt;
    logic          overflow;
    pwf_pkg::meter_state_t state_dbg;

    always #125 clk4m = ~clk4m;

    pwf_pulse_meter_if #(.CNT_W(CW)) meas_if ();

    pwf_pulse_meter #(
        .CNT_W  (CW),
        .DEPTH  (DEP),
        .PCNT_W (PW)
    ) dut (
        .clk4m     (clk4m),
        .rst_n     (rst_n),
        .c_in      (c_in),
        .clr       (clr),
        .meas      (meas_if.master),
        .pulse_cnt (pulse_cnt),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds {sat, width} of results visible to the host, in order.
    logic [CW:0] exp_q[$];
    bit          pend;
    logic [CW:0] pend_val;
    bit          prev_c;
    bit          in_pulse;
    int          run;
    int          m_pcnt;
    bit          m_ov;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend     = 0;
        prev_c   = 1;
        in_pulse = 0;
        run      = 0;
        m_pcnt   = 0;
        m_ov     = 0;
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit c, input bit rdy, input bit cl);
        int sz;
        bit pp;
        sz = exp_q.size();
        pp = (sz > 0) && rdy;
        if (pp) void'(exp_q.pop_front());
        if (pend) begin
            if (sz == DEP && !pp) m_ov = 1;
            else                  exp_q.push_back(pend_val);
        end
        pend = 0;
        if (in_pulse) begin
            if (c) run++;
            else begin
                pend        = 1;
                pend_val[CW] = (run > MAXW);
                pend_val[CW-1:0] = (run > MAXW) ? CW'(MAXW) : CW'(run);
                m_pcnt      = (m_pcnt + 1) % (1 << PW);
                in_pulse    = 0;
            end
        end else if (c && !prev_c) begin
            in_pulse = 1;
            run      = 1;
        end
        prev_c = c;
        if (cl) begin
            m_pcnt = 0;
            m_ov   = 0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_valid"}, meas_if.meas_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check({pfx, "_width"}, meas_if.meas_width, exp_q[0][CW-1:0]);
            check({pfx, "_sat"},   meas_if.meas_sat,   exp_q[0][CW]);
        end
        check({pfx, "_pcnt"}, pulse_cnt, m_pcnt);
        check({pfx, "_ovf"},  overflow,  m_ov);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit c, input bit rdy, input bit cl);
        @(negedge clk4m);
        c_in = c;
        meas_if.meas_ready = rdy;
        clr = cl;
        model_edge(c, rdy, cl);
        @(posedge clk4m);
        #1;
        check_outputs("cyc");
    endtask

    task automatic pulse(input int n, input int gap, input bit rdy);
        for (int i = 0; i < n; i++)   step(1, rdy, 0);
        for (int i = 0; i < gap; i++) step(0, rdy, 0);
    endtask

    task automatic do_reset(input bit c, input int cyc);
        c_in  = c;
        rst_n = 0;
        model_reset();
        #1;
        check("rst_valid", meas_if.meas_valid, 0);
        check("rst_width", meas_if.meas_width, 0);
        check("rst_sat",   meas_if.meas_sat,   0);
        check("rst_pcnt",  pulse_cnt,          0);
        check("rst_ovf",   overflow,           0);
        repeat (cyc) @(negedge clk4m);
        rst_n = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len;
        int gap;
        meas_if.meas_ready = 0;
        // 1: 13-cycle pulse
        do_reset(0, 2);
        step(0, 0, 0);
        pulse(13, 1, 0);
        check("s1_valid_lat", meas_if.meas_valid, 0);
        step(0, 0, 0);
        check("s1_width", meas_if.meas_width, 13);
        check("s1_sat",   meas_if.meas_sat,   0);
        check("s1_pcnt",  pulse_cnt,          1);
        // 2: pop, then a 10-cycle pulse with ready held high
        step(0, 1, 0);
        pulse(10, 2, 1);
        check("s2_width", meas_if.meas_width, 10);
        check("s2_pcnt",  pulse_cnt,          2);
        step(0, 1, 0);
        check("s2_valid_drop", meas_if.meas_valid, 0);
        // 3: saturation then a short pulse
        pulse(20, 2, 0);
        check("s3_width", meas_if.meas_width, MAXW);
        check("s3_sat",   meas_if.meas_sat,   1);
        step(0, 1, 0);
        pulse(3, 2, 0);
        check("s3b_width", meas_if.meas_width, 3);
        check("s3b_sat",   meas_if.meas_sat,   0);
        step(0, 1, 0);
        // 4: overflow with five pulses while stalled
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) pulse(2, 1, 0);
        step(0, 0, 0);
        check("s4_ovf",  overflow,  1);
        check("s4_pcnt", pulse_cnt, 5);
        for (int i = 0; i < 4; i++) begin
            check("s4_pop_width", meas_if.meas_width, 2);
            step(0, 1, 0);
        end
        check("s4_empty", meas_if.meas_valid, 0);
        step(0, 0, 1);
        check("s4_clr_ovf",  overflow,  0);
        check("s4_clr_pcnt", pulse_cnt, 0);
        // 5: pulse already high at reset release
        do_reset(1, 2);
        pulse(6, 1, 0);
        step(0, 0, 0);
        check("s5_no_entry", meas_if.meas_valid, 0);
        check("s5_pcnt",     pulse_cnt,          0);
        pulse(4, 2, 0);
        check("s5_width", meas_if.meas_width, 4);
        // 6: reset mid-pulse
        step(0, 1, 0);
        pulse(5, 0, 0);
        #40;
        do_reset(1, 2);
        pulse(3, 3, 0);
        check("s6_no_entry", meas_if.meas_valid, 0);
        check("s6_pcnt",     pulse_cnt,          0);
        // random traffic with random ready and occasional clr
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 4) == 0) len = $urandom_range(17, 24);
            gap = $urandom_range(1, 4);
            for (int i = 0; i < len + gap; i++)
                step(i < len, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
